jtag_tap_responder: RTL and testbench
=====================================

JTAG_TAP_RESPONDER -- requirements
Module: jtag_tap_responder

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 5, giving the instruction register width.
REQ-002 SHALL have parameter IDCODE_VALUE, default 32'h20000913, as the IDCODE DR content; bit 0 SHALL be 1.
REQ-003 SHALL have parameter USER_INSN, default 5'h10, as the instruction selecting the 32-bit user DR.
REQ-004 SHALL have port clock, input, 1 bit: system clock; all state updates occur on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port jtag_TCK, input, 1 bit: test clock, sampled as data and asynchronous to clock.
REQ-007 SHALL have port jtag_TMS, input, 1 bit: test mode select.
REQ-008 SHALL have port jtag_TDI, input, 1 bit: test data in.
REQ-009 SHALL have port jtag_TRSTn, input, 1 bit: active-low test reset.
REQ-010 SHALL have port jtag_TDO_data, output, 1 bit: test data out value.
REQ-011 SHALL have port jtag_TDO_driven, output, 1 bit: high when jtag_TDO_data is valid.
REQ-012 SHALL have port tap_state, output, 4 bits: current TAP state in IEEE 1149.1 encoding.
REQ-013 SHALL have port ir_value, output, IR_WIDTH bits: current instruction.
REQ-014 SHALL have port user_capture_data, input, 32 bits: value loaded into the user DR at Capture-DR.
REQ-015 SHALL have port user_update_data, output, 32 bits: user DR contents latched at Update-DR.
REQ-016 SHALL have port user_update_valid, output, 1 bit: single-cycle pulse marking new user_update_data.

Function
REQ-017 SHALL pass TCK, TMS, TDI and TRSTn through a 2-flop synchronizer, plus one additional TCK flop for edge detection.
REQ-018 SHALL define a rise event as synced TCK=1 with previous=0, and a fall event as synced TCK=0 with previous=1; each event lasts exactly one clock cycle.
REQ-019 SHALL operate correctly when each TCK phase lasts at least 3 clock periods; behaviour with shorter phases is undefined.
REQ-020 SHALL encode states as: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.
REQ-021 SHALL advance the state only on a rise event, using synced TMS and the standard IEEE 1149.1 transition table.
REQ-022 SHALL, on a rise event in CapIR, load the IR shift register with {0..., 2'b01}.
REQ-023 SHALL, on a rise event in CapDR, load the selected DR: IDCODE_VALUE, user_capture_data, or 0 for bypass.
REQ-024 SHALL, on a rise event in ShIR/ShDR, shift the selected register right one bit, inserting synced TDI at the MSB.
REQ-025 SHALL select the DR from ir_value: 5'h01 selects IDCODE (32 bits); USER_INSN selects user (32 bits); any other value selects 1-bit bypass.
REQ-026 SHALL, on a fall event in ShIR/ShDR, set jtag_TDO_data to the LSB of the shifting register and jtag_TDO_driven to 1.
REQ-027 SHALL, on a fall event in any other state, set jtag_TDO_driven to 0 and hold jtag_TDO_data.
REQ-028 SHALL, on a fall event in UpdIR, copy the IR shift register to ir_value.
REQ-029 SHALL, on a fall event in UpdDR with the user DR selected, copy it to user_update_data and pulse user_update_valid for exactly 1 clock.
REQ-030 SHALL, when synced TRSTn=0, force TLR and ir_value=5'h01 each cycle, overriding any TCK event.
REQ-031 SHALL, on entry to TLR by any path, set ir_value=5'h01; user_update_data SHALL be unaffected.
REQ-032 SHALL NOT modify ir_value or user_update_data when traversal passes through Pause or Exit states.

Reset
REQ-033 SHALL, with reset high, set tap_state=F, ir_value=5'h01, jtag_TDO_data=0, jtag_TDO_driven=0, user_update_data=0, user_update_valid=0, and clear the synchronizers and shift registers to 0.
REQ-034 SHALL ignore TCK edges pending at reset release; the first rise event SHALL be the first rise after reset deasserts.

Verification
REQ-035 SHALL be covered by: reset pulse -> tap_state=F, ir_value=01, TDO_driven=0.
REQ-036 SHALL be covered by: 5 TCK cycles with TMS=1 from ShDR -> tap_state=F.
REQ-037 SHALL be covered by: after reset, TMS 0,1,0,0 then 32 shifts -> TDO emits 0x20000913 LSB first, with driven=1 during the shifts.
REQ-038 SHALL be covered by: load IR=5'h1F, then shift DR pattern 1,0,1,1 -> TDO emits 0,1,0,1,1 (one-TCK delay).
REQ-039 SHALL be covered by: IR=USER_INSN with user_capture_data=0x12345678, shift in 0xDEADBEEF, then UpdDR -> TDO emits 0x12345678, then user_update_data=0xDEADBEEF with a 1-cycle valid pulse.
REQ-040 SHALL be covered by: TRSTn low for 1 TCK during ShDR -> tap_state=F within 3 clocks, ir_value=01, and no update pulse.

Source files
------------

// File: rtl/jtag_tap_responder.sv
// JTAG TAP responder that oversamples TCK/TMS/TDI/TRSTn on the system clock.
// It provides IDCODE, a 32-bit user data register and 1-bit bypass.
module jtag_tap_responder #(
    parameter int                  IR_WIDTH     = 5,
    parameter logic [31:0]         IDCODE_VALUE = 32'h20000913,
    parameter logic [IR_WIDTH-1:0] USER_INSN    = IR_WIDTH'(5'h10)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                jtag_TCK,
    input  logic                jtag_TMS,
    input  logic                jtag_TDI,
    input  logic                jtag_TRSTn,
    output logic                jtag_TDO_data,
    output logic                jtag_TDO_driven,
    output logic [3:0]          tap_state,
    output logic [IR_WIDTH-1:0] ir_value,
    input  logic [31:0]         user_capture_data,
    output logic [31:0]         user_update_data,
    output logic                user_update_valid
);

    typedef enum logic [3:0] {
        TLR     = 4'hF, RTI     = 4'hC, SEL_DR  = 4'h7, CAP_DR  = 4'h6,
        SH_DR   = 4'h2, EX1_DR  = 4'h1, PAUSE_DR = 4'h3, EX2_DR = 4'h0,
        UPD_DR  = 4'h5, SEL_IR  = 4'h4, CAP_IR  = 4'hE, SH_IR   = 4'hA,
        EX1_IR  = 4'h9, PAUSE_IR = 4'hB, EX2_IR = 4'h8, UPD_IR  = 4'hD
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

    // Synchronizer bit order: {trstn, tdi, tms, tck}
    logic [3:0]          sync1_q, sync2_q;
    logic                tck_prev_q;
    logic [1:0]          fill_q;
    tap_state_e          state_q, state_d;
    logic [IR_WIDTH-1:0] ir_q, ir_shift_q;
    logic [31:0]         dr_shift_q, dr_capture;
    logic [31:0]         update_data_q;
    logic                update_valid_q, tdo_data_q, tdo_driven_q;
    logic                tck_s, tms_s, tdi_s, trstn_s;
    logic                sync_ready, rise, fall, sel_idcode, sel_user;

    assign tck_s   = sync2_q[0];
    assign tms_s   = sync2_q[1];
    assign tdi_s   = sync2_q[2];
    assign trstn_s = sync2_q[3];

    // Edges only count once the whole TCK pipeline holds post-reset samples,
    // so a TCK level already high at reset release is not seen as a rise.
    assign sync_ready = (fill_q == 2'd3);
    assign rise       = sync_ready &&  tck_s && !tck_prev_q;
    assign fall       = sync_ready && !tck_s &&  tck_prev_q;

    assign sel_idcode = (ir_q == IR_IDCODE);
    assign sel_user   = !sel_idcode && (ir_q == USER_INSN);

    always_comb begin
        dr_capture = 32'd0;
        if (sel_idcode) begin
            dr_capture = IDCODE_VALUE;
        end else if (sel_user) begin
            dr_capture = user_capture_data;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:      state_d = tms_s ? TLR      : RTI;
            RTI:      state_d = tms_s ? SEL_DR   : RTI;
            SEL_DR:   state_d = tms_s ? SEL_IR   : CAP_DR;
            CAP_DR:   state_d = tms_s ? EX1_DR   : SH_DR;
            SH_DR:    state_d = tms_s ? EX1_DR   : SH_DR;
            EX1_DR:   state_d = tms_s ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_d = tms_s ? EX2_DR   : PAUSE_DR;
            EX2_DR:   state_d = tms_s ? UPD_DR   : SH_DR;
            UPD_DR:   state_d = tms_s ? SEL_DR   : RTI;
            SEL_IR:   state_d = tms_s ? TLR      : CAP_IR;
            CAP_IR:   state_d = tms_s ? EX1_IR   : SH_IR;
            SH_IR:    state_d = tms_s ? EX1_IR   : SH_IR;
            EX1_IR:   state_d = tms_s ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_d = tms_s ? EX2_IR   : PAUSE_IR;
            EX2_IR:   state_d = tms_s ? UPD_IR   : SH_IR;
            UPD_IR:   state_d = tms_s ? SEL_DR   : RTI;
            default:  state_d = TLR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q        <= 4'd0;
            sync2_q        <= 4'd0;
            tck_prev_q     <= 1'b0;
            fill_q         <= 2'd0;
            state_q        <= TLR;
            ir_q           <= IR_IDCODE;
            ir_shift_q     <= '0;
            dr_shift_q     <= 32'd0;
            update_data_q  <= 32'd0;
            update_valid_q <= 1'b0;
            tdo_data_q     <= 1'b0;
            tdo_driven_q   <= 1'b0;
        end else begin
            sync1_q        <= {jtag_TRSTn, jtag_TDI, jtag_TMS, jtag_TCK};
            sync2_q        <= sync1_q;
            tck_prev_q     <= tck_s;
            update_valid_q <= 1'b0;
            if (!sync_ready) begin
                fill_q <= fill_q + 2'd1;
            end

            if (!trstn_s) begin
                state_q      <= TLR;
                ir_q         <= IR_IDCODE;
                tdo_driven_q <= 1'b0;
            end else if (rise) begin
                state_q <= state_d;
                if (state_d == TLR) begin
                    ir_q <= IR_IDCODE;
                end
                case (state_q)
                    CAP_IR: ir_shift_q <= IR_CAPTURE;
                    SH_IR:  ir_shift_q <= {tdi_s, ir_shift_q[IR_WIDTH-1:1]};
                    CAP_DR: dr_shift_q <= dr_capture;
                    SH_DR: begin
                        if (sel_idcode || sel_user) begin
                            dr_shift_q <= {tdi_s, dr_shift_q[31:1]};
                        end else begin
                            dr_shift_q[0] <= tdi_s;
                        end
                    end
                    default: ;
                endcase
            end else if (fall) begin
                tdo_driven_q <= 1'b0;
                case (state_q)
                    SH_IR: begin
                        tdo_data_q   <= ir_shift_q[0];
                        tdo_driven_q <= 1'b1;
                    end
                    SH_DR: begin
                        tdo_data_q   <= dr_shift_q[0];
                        tdo_driven_q <= 1'b1;
                    end
                    UPD_IR: ir_q <= ir_shift_q;
                    UPD_DR: begin
                        if (sel_user) begin
                            update_data_q  <= dr_shift_q;
                            update_valid_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign jtag_TDO_data     = tdo_data_q;
    assign jtag_TDO_driven   = tdo_driven_q;
    assign tap_state         = state_q;
    assign ir_value          = ir_q;
    assign user_update_data  = update_data_q;
    assign user_update_valid = update_valid_q;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench for jtag_tap_responder: drives slow TCK cycles and checks
// TAP state, shifted TDO streams, IR/DR updates and TRSTn behaviour.
module tb_jtag_tap_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
    logic        jtag_TDO_data, jtag_TDO_driven;
    logic [3:0]  tap_state;
    logic [4:0]  ir_value;
    logic [31:0] user_capture_data;
    logic [31:0] user_update_data;
    logic        user_update_valid;

    int err_cnt   = 0;
    int check_cnt = 0;
    int pulse_cnt = 0;

    jtag_tap_responder dut (
        .clock             (clock),
        .reset             (reset),
        .jtag_TCK          (jtag_TCK),
        .jtag_TMS          (jtag_TMS),
        .jtag_TDI          (jtag_TDI),
        .jtag_TRSTn        (jtag_TRSTn),
        .jtag_TDO_data     (jtag_TDO_data),
        .jtag_TDO_driven   (jtag_TDO_driven),
        .tap_state         (tap_state),
        .ir_value          (ir_value),
        .user_capture_data (user_capture_data),
        .user_update_data  (user_update_data),
        .user_update_valid (user_update_valid)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (user_update_valid) begin
            pulse_cnt <= pulse_cnt + 1;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_cnt++;
        if (actual !== expected) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end else begin
            $display("ok   %s: 0x%08h", tag, actual);
        end
    endtask

    // One TCK period: high phase then low phase, 5 system clocks each.
    task automatic tck_cycle(input logic tms, input logic tdi);
        jtag_TMS = tms;
        jtag_TDI = tdi;
        jtag_TCK = 1'b1;
        repeat (5) @(negedge clock);
        jtag_TCK = 1'b0;
        repeat (5) @(negedge clock);
    endtask

    // TDO is sampled before each shift cycle; the last cycle exits to Exit1.
    task automatic shift_bits(input int n, input logic [31:0] din,
                              output logic [31:0] dout, output logic drv_all);
        dout    = 32'd0;
        drv_all = 1'b1;
        for (int i = 0; i < n; i++) begin
            dout[i] = jtag_TDO_data;
            drv_all = drv_all & jtag_TDO_driven;
            tck_cycle(i == n - 1, din[i]);
        end
    endtask

    task automatic load_ir(input logic [4:0] insn);
        logic [31:0] dout;
        logic        drv;
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        shift_bits(5, 32'(insn), dout, drv);
        check_value("ir_capture_out", dout, 32'h01);
        tck_cycle(1'b1, 1'b0);
        check_value("ir_update", 32'(ir_value), 32'(insn));
        tck_cycle(1'b0, 1'b0);
    endtask

    task automatic goto_shift_dr();
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] dout;
        logic        drv;
        int          pulses_before;

        reset             = 1'b1;
        jtag_TCK          = 1'b0;
        jtag_TMS          = 1'b1;
        jtag_TDI          = 1'b0;
        jtag_TRSTn        = 1'b1;
        user_capture_data = 32'h12345678;
        repeat (5) @(negedge clock);
        check_value("rst_state", 32'(tap_state), 32'hF);
        check_value("rst_ir", 32'(ir_value), 32'h01);
        check_value("rst_driven", 32'(jtag_TDO_driven), 32'h0);
        check_value("rst_tdo", 32'(jtag_TDO_data), 32'h0);
        check_value("rst_upd_data", user_update_data, 32'h0);
        check_value("rst_upd_valid", 32'(user_update_valid), 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // IDCODE read straight out of reset
        tck_cycle(1'b0, 1'b0);
        check_value("tlr_to_rti", 32'(tap_state), 32'hC);
        goto_shift_dr();
        check_value("in_shift_dr", 32'(tap_state), 32'h2);
        shift_bits(32, 32'h0, dout, drv);
        check_value("idcode_out", dout, 32'h20000913);
        check_value("idcode_driven", 32'(drv), 32'h1);
        check_value("ex1dr_state", 32'(tap_state), 32'h1);
        check_value("ex1dr_undriven", 32'(jtag_TDO_driven), 32'h0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);

        // Five TMS=1 cycles from Shift-DR reach Test-Logic-Reset
        pulses_before = pulse_cnt;
        goto_shift_dr();
        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
        check_value("tms5_state", 32'(tap_state), 32'hF);
        check_value("tms5_ir", 32'(ir_value), 32'h01);
        check_value("tms5_no_pulse", 32'(pulse_cnt - pulses_before), 32'h0);
        tck_cycle(1'b0, 1'b0);

        // Bypass: one-TCK delay through the 1-bit register
        load_ir(5'h1F);
        goto_shift_dr();
        shift_bits(5, 32'b01101, dout, drv);
        check_value("bypass_out", dout, 32'b11010);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);

        // User DR capture, shift and update
        load_ir(5'h10);
        pulses_before = pulse_cnt;
        goto_shift_dr();
        shift_bits(32, 32'hDEADBEEF, dout, drv);
        check_value("user_capture_out", dout, 32'h12345678);
        tck_cycle(1'b1, 1'b0);
        check_value("upd_dr_state", 32'(tap_state), 32'h5);
        check_value("user_update_data", user_update_data, 32'hDEADBEEF);
        check_value("user_valid_pulses", 32'(pulse_cnt - pulses_before), 32'h1);
        tck_cycle(1'b0, 1'b0);

        // Entering TLR via Select-IR restores IDCODE, keeps user data
        for (int i = 0; i < 3; i++) tck_cycle(1'b1, 1'b0);
        check_value("tlr_entry_state", 32'(tap_state), 32'hF);
        check_value("tlr_entry_ir", 32'(ir_value), 32'h01);
        check_value("tlr_keeps_user", user_update_data, 32'hDEADBEEF);
        tck_cycle(1'b0, 1'b0);

        // TRSTn asserted mid Shift-DR with the user DR selected
        load_ir(5'h10);
        pulses_before = pulse_cnt;
        goto_shift_dr();
        tck_cycle(1'b0, 1'b1);
        tck_cycle(1'b0, 1'b0);
        jtag_TRSTn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_value("trst_state_3clk", 32'(tap_state), 32'hF);
        @(negedge clock);
        tck_cycle(1'b1, 1'b0);
        jtag_TRSTn = 1'b1;
        repeat (5) @(negedge clock);
        check_value("trst_state", 32'(tap_state), 32'hF);
        check_value("trst_ir", 32'(ir_value), 32'h01);
        check_value("trst_no_pulse", 32'(pulse_cnt - pulses_before), 32'h0);
        check_value("trst_keeps_user", user_update_data, 32'hDEADBEEF);

        $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
        $finish;
    end

endmodule
